kmap_truth_table_scanner: RTL and testbench
===========================================

Name: kmap_truth_table_scanner

Overview:
Sequential characterizer for an external N-input combinational function (a K-map implementation).
- Sweeps every input vector on probe outputs, waits a settle interval, then samples the function's 1-bit output.
- Assembles the full truth table, counts minterms and compares the table against an expected table.
- Sits beside combinational logic blocks as a built-in self-check engine, driven by a controller over a start/done/ack handshake.

Parameters:
N_IN, 4, number of function inputs; TABLE_W = 2**N_IN (derived, 16).
SETTLE_CYCLES, 1, cycles a probe vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  clock, all state updates on rising edge
areset  input  1  asynchronous active-high reset
start  input  1  begin scan; accepted only in IDLE
abort  input  1  cancel scan; returns to IDLE
ack  input  1  consume result; accepted only in DONE
exp_table  input  TABLE_W  expected truth table, captured on start accept
func_in  input  1  output of the function under scan
probe  output  N_IN  input vector driven to the function; probe[N_IN-1] = a ... probe[0] = d
busy  output  1  high in SETTLE or SAMPLE
done  output  1  result valid, held until ack
truth_table  output  TABLE_W  bit k = func_in sampled with probe == k
ones_count  output  N_IN+1  number of 1 bits in truth_table (0..16)
mismatch_mask  output  TABLE_W  truth_table XOR captured exp_table; valid when done
match  output  1  done AND mismatch_mask == 0

Behaviour:
- Reset (async, immediate, any state):
  - State goes to IDLE.
  - probe, truth_table, ones_count, mismatch_mask and the exp_table capture register clear to 0.
  - busy, done and match go to 0.
- IDLE:
  - start=1 and abort=0 at an edge: clear truth_table and ones_count; set probe=0 and settle counter=0; capture exp_table; go to SETTLE.
  - start and abort both high: abort wins and no scan begins.
- SETTLE: hold probe for SETTLE_CYCLES cycles, counting, then go to SAMPLE.
- SAMPLE (one cycle): at the closing edge, write func_in into truth_table[probe] and add func_in to ones_count.
  - probe == TABLE_W-1: go to DONE.
  - Otherwise probe increments by 1 and the state returns to SETTLE.
- Timing:
  - Vector k is captured at edge (k+1)*(SETTLE_CYCLES+1) after the start-accept edge.
  - done first reads high after edge TABLE_W*(SETTLE_CYCLES+1): 32 cycles for the defaults, 64 for SETTLE_CYCLES=3.
- DONE:
  - done=1; truth_table, ones_count, mismatch_mask and match are stable.
  - probe holds TABLE_W-1.
  - start is ignored.
  - ack=1 goes to IDLE; done, match and mismatch_mask clear at that edge, truth_table and ones_count hold.
- abort in SETTLE or SAMPLE:
  - Go to IDLE next edge; the sample in progress is not written.
  - Partial truth_table and ones_count hold; done never asserts.
- abort in DONE acts as ack.
- Status outputs:
  - busy is registered and matches the state.
  - mismatch_mask and match are registered on entry to DONE.
- Arithmetic and probe rules:
  - ones_count saturation cannot occur, since the maximum is TABLE_W.
  - The probe counter does not wrap during a scan; it wraps to 0 only on the next start accept.
- func_in is treated as already synchronous to clk; no synchronizer.

Decomposition:
- Package kmap_scan_pkg holds:
  - the state enum {IDLE, SETTLE, SAMPLE, DONE};
  - a TABLE_W function of N_IN;
  - the width constant for the settle counter (4 bits).
- One natural sub-module, kmap_settle_timer: a loadable down-counter with a zero flag, parameterized by SETTLE_CYCLES.
- All other logic stays in the top module.

Test Plan:
- Function func=(~c&~b)|(~d&~a)|(a&c&d)|(b&c&d), exp_table=16'h8BD7, pulse start -> done after 32 cycles, truth_table=16'h8BD7, ones_count=10, mismatch_mask=0, match=1; ack -> done=0 next cycle.
- func_in=probe[0] -> truth_table=16'hAAAA, ones_count=8; func_in=probe[3] -> 16'hFF00; func_in=0 -> 16'h0000 with ones_count=0.
- Same function as scenario 1, exp_table=16'h8BD6 -> mismatch_mask=16'h0001, match=0, done=1 held for 10 cycles without ack, outputs stable.
- SETTLE_CYCLES=3 -> probe changes every 4 cycles and done rises 64 cycles after start; start pulsed in DONE is ignored, and start and abort together in IDLE keep busy=0.
- abort after 5 samples -> IDLE next edge, truth_table bits 4:0 hold and bits 15:5 are 0, done never rises; a new start completes a full scan correctly.
- areset asserted mid-SETTLE between edges -> outputs zero immediately without waiting for a clock; after release, start produces a correct full scan.

Source files
------------

// File: rtl/kmap_scan_pkg.sv
// Shared types and constants for the truth-table scanner and its settle timer.
package kmap_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } scan_state_e;

   localparam int SETTLE_CNT_W = 4;

   function automatic int table_w(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/kmap_settle_timer.sv
// Loadable down-counter; zero flags the last cycle a probe vector must be held.
module kmap_settle_timer
   import kmap_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic areset,
   input  logic load,
   input  logic en,
   output logic zero
);

   logic [SETTLE_CNT_W-1:0] count_q;
   logic [SETTLE_CNT_W-1:0] count_d;

   // Loading SETTLE_CYCLES-1 makes zero true on the last of SETTLE_CYCLES hold cycles.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
      end else if (en && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/kmap_truth_table_scanner.sv
// Sweeps all input vectors of an external function, builds its truth table,
// counts minterms and compares the table against an expected table.
module kmap_truth_table_scanner
   import kmap_scan_pkg::*;
#(
   parameter  int N_IN          = 4,
   parameter  int SETTLE_CYCLES = 1,
   localparam int TABLE_W       = table_w(N_IN)
) (
   input  logic               clk,
   input  logic               areset,
   input  logic               start,
   input  logic               abort,
   input  logic               ack,
   input  logic [TABLE_W-1:0] exp_table,
   input  logic               func_in,
   output logic [N_IN-1:0]    probe,
   output logic               busy,
   output logic               done,
   output logic [TABLE_W-1:0] truth_table,
   output logic [N_IN:0]      ones_count,
   output logic [TABLE_W-1:0] mismatch_mask,
   output logic               match
);

   localparam logic [N_IN-1:0] PROBE_LAST = '1;

   scan_state_e        state_q, state_d;
   logic [N_IN-1:0]    probe_q, probe_d;
   logic [TABLE_W-1:0] table_q, table_d;
   logic [N_IN:0]      ones_q, ones_d;
   logic [TABLE_W-1:0] exp_q, exp_d;
   logic [TABLE_W-1:0] mask_q, mask_d;
   logic               match_q, match_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               timer_load;
   logic               timer_en;
   logic               timer_zero;

   kmap_settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk   (clk),
      .areset(areset),
      .load  (timer_load),
      .en    (timer_en),
      .zero  (timer_zero)
   );

   always_comb begin
      state_d    = state_q;
      probe_d    = probe_q;
      table_d    = table_q;
      ones_d     = ones_q;
      exp_d      = exp_q;
      mask_d     = mask_q;
      match_d    = match_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               table_d    = '0;
               ones_d     = '0;
               probe_d    = '0;
               exp_d      = exp_table;
               timer_load = 1'b1;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (timer_zero) begin
               state_d = SAMPLE;
            end else begin
               timer_en = 1'b1;
            end
         end
         SAMPLE: begin
            // An abort here drops the sample in progress.
            if (abort) begin
               state_d = IDLE;
            end else begin
               table_d[probe_q] = func_in;
               ones_d           = ones_q + (N_IN+1)'(func_in);
               if (probe_q == PROBE_LAST) begin
                  mask_d  = table_d ^ exp_q;
                  match_d = ((table_d ^ exp_q) == '0);
                  state_d = DONE;
               end else begin
                  probe_d    = probe_q + 1'b1;
                  timer_load = 1'b1;
                  state_d    = SETTLE;
               end
            end
         end
         DONE: begin
            if (ack || abort) begin
               mask_d  = '0;
               match_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         probe_q <= '0;
         table_q <= '0;
         ones_q  <= '0;
         exp_q   <= '0;
         mask_q  <= '0;
         match_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         probe_q <= probe_d;
         table_q <= table_d;
         ones_q  <= ones_d;
         exp_q   <= exp_d;
         mask_q  <= mask_d;
         match_q <= match_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign probe         = probe_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign truth_table   = table_q;
   assign ones_count    = ones_q;
   assign mismatch_mask = mask_q;
   assign match         = match_q;

endmodule

// File: tb/tb_kmap_truth_table_scanner.sv
// Randomized self-checking bench: two scanners (settle 1 and 3) against a truth-table model.
module tb_kmap_truth_table_scanner;

   logic clk = 1'b0;
   logic areset;
   always #5 clk = ~clk;

   logic        start_a, abort_a, ack_a, func_a, busy_a, done_a, match_a;
   logic [15:0] exp_a, tt_a, mask_a;
   logic [3:0]  probe_a;
   logic [4:0]  ones_a;

   logic        start_b, abort_b, ack_b, func_b, busy_b, done_b, match_b;
   logic [15:0] exp_b, tt_b, mask_b;
   logic [3:0]  probe_b;
   logic [4:0]  ones_b;

   int          mode_a, mode_b;
   logic [15:0] rand_tt;
   int          n_vec = 0;
   int          n_err = 0;

   kmap_truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .areset(areset), .start(start_a), .abort(abort_a), .ack(ack_a),
      .exp_table(exp_a), .func_in(func_a), .probe(probe_a), .busy(busy_a),
      .done(done_a), .truth_table(tt_a), .ones_count(ones_a),
      .mismatch_mask(mask_a), .match(match_a)
   );

   kmap_truth_table_scanner #(.N_IN(4), .SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .areset(areset), .start(start_b), .abort(abort_b), .ack(ack_b),
      .exp_table(exp_b), .func_in(func_b), .probe(probe_b), .busy(busy_b),
      .done(done_b), .truth_table(tt_b), .ones_count(ones_b),
      .mismatch_mask(mask_b), .match(match_b)
   );

   // Function under scan: 0 kmap, 1 d, 2 a, 3 const 0, otherwise lookup table.
   function automatic logic f_eval(input int mode, input logic [3:0] v, input logic [15:0] tbl);
      logic a, b, c, d;
      a = v[3]; b = v[2]; c = v[1]; d = v[0];
      case (mode)
         0: return (~c & ~b) | (~d & ~a) | (a & c & d) | (b & c & d);
         1: return d;
         2: return a;
         3: return 1'b0;
         default: return tbl[v];
      endcase
   endfunction

   function automatic logic [15:0] model_tt(input int mode, input logic [15:0] tbl);
      logic [15:0] t;
      t = '0;
      for (int k = 0; k < 16; k++) t[k] = f_eval(mode, 4'(k), tbl);
      return t;
   endfunction

   assign func_a = f_eval(mode_a, probe_a, rand_tt);
   assign func_b = f_eval(mode_b, probe_b, rand_tt);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic scan_a(input int mode, input logic [15:0] expt);
      logic [15:0] m;
      int cyc;
      m = model_tt(mode, rand_tt);
      mode_a = mode;
      @(negedge clk);
      start_a = 1'b1;
      exp_a   = expt;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      exp_a   = ~expt;
      check("busy_after_start", 32'(busy_a), 32'd1);
      cyc = 0;
      while (!done_a && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("done_latency", cyc, 32);
      check("truth_table", 32'(tt_a), 32'(m));
      check("ones_count", 32'(ones_a), 32'($countones(m)));
      check("mismatch_mask", 32'(mask_a), 32'(m ^ expt));
      check("match", 32'(match_a), 32'(m == expt));
      check("busy_in_done", 32'(busy_a), 32'd0);
      $display("scan mode=%0d exp=%h tt=%h ones=%0d mask=%h match=%0d",
               mode, expt, tt_a, ones_a, mask_a, match_a);
   endtask

   task automatic ack_a_pulse(input logic [15:0] m);
      @(negedge clk);
      ack_a = 1'b1;
      @(posedge clk);
      #1;
      ack_a = 1'b0;
      check("ack_done", 32'(done_a), 32'd0);
      check("ack_match", 32'(match_a), 32'd0);
      check("ack_mask", 32'(mask_a), 32'd0);
      check("ack_tt_hold", 32'(tt_a), 32'(m));
   endtask

   initial begin
      logic [15:0] m, e, hold_tt;
      int cyc;
      logic saw_done;

      areset = 1'b1;
      {start_a, abort_a, ack_a, start_b, abort_b, ack_b} = '0;
      exp_a = '0; exp_b = '0; mode_a = 3; mode_b = 3; rand_tt = '0;
      repeat (2) @(negedge clk);
      check("rst_probe", 32'(probe_a), 32'd0);
      check("rst_tt", 32'(tt_a), 32'd0);
      check("rst_flags", 32'({busy_a, done_a, match_a, ones_a, mask_a}), 32'd0);
      areset = 1'b0;

      // Reference kmap function with matching and off-by-one expected tables.
      scan_a(0, 16'h8BD7);
      check("kmap_const", 32'(tt_a), 32'h8BD7);
      check("kmap_ones", 32'(ones_a), 32'd10);
      ack_a_pulse(16'h8BD7);
      scan_a(1, 16'hAAAA);
      check("d_const", 32'(tt_a), 32'hAAAA);
      ack_a_pulse(16'hAAAA);
      scan_a(2, 16'hFF00);
      check("a_const", 32'(tt_a), 32'hFF00);
      ack_a_pulse(16'hFF00);
      scan_a(3, 16'h0000);
      check("zero_ones", 32'(ones_a), 32'd0);
      ack_a_pulse(16'h0000);
      scan_a(0, 16'h8BD6);
      check("mm_mask_const", 32'(mask_a), 32'h0001);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_done", 32'(done_a), 32'd1);
         check("hold_tt", 32'(tt_a), 32'h8BD7);
         check("hold_mask", 32'(mask_a), 32'h0001);
      end
      ack_a_pulse(16'h8BD7);

      for (int i = 0; i < 6; i++) begin
         rand_tt = 16'($urandom);
         e = ($urandom_range(0, 1) == 1) ? rand_tt : (rand_tt ^ 16'($urandom));
         scan_a(4, e);
         ack_a_pulse(rand_tt);
      end

      // Abort after five samples (vector 4 captured at edge 10).
      mode_a = 0;
      m = model_tt(0, rand_tt);
      @(negedge clk);
      start_a = 1'b1;
      exp_a   = 16'h8BD7;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      abort_a = 1'b1;
      @(posedge clk);
      #1;
      abort_a = 1'b0;
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_tt", 32'(tt_a), 32'(m & 16'h001F));
      check("abort_ones", 32'(ones_a), 32'($countones(m & 16'h001F)));
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done_a;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      $display("abort tt=%h ones=%0d", tt_a, ones_a);
      scan_a(0, 16'h8BD7);
      ack_a_pulse(16'h8BD7);

      // Asynchronous reset in the middle of SETTLE.
      mode_a = 1;
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("pre_rst_probe", 32'(probe_a), 32'd3);
      @(negedge clk);
      areset = 1'b1;
      #1;
      check("arst_probe", 32'(probe_a), 32'd0);
      check("arst_tt", 32'(tt_a), 32'd0);
      check("arst_flags", 32'({busy_a, done_a, ones_a}), 32'd0);
      $display("async reset applied mid-settle");
      @(negedge clk);
      areset = 1'b0;
      scan_a(0, 16'h8BD7);
      ack_a_pulse(16'h8BD7);

      // Settle of three cycles: probe steps every four cycles.
      mode_b = 0;
      @(negedge clk);
      start_b = 1'b1;
      exp_b   = 16'h8BD7;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      cyc = 0;
      while (!done_b && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         check("b_probe", 32'(probe_b), 32'((cyc / 4 > 15) ? 15 : cyc / 4));
      end
      check("b_latency", cyc, 64);
      check("b_tt", 32'(tt_b), 32'h8BD7);
      check("b_match", 32'(match_b), 32'd1);
      $display("scan settle=3 tt=%h latency=%0d", tt_b, cyc);
      hold_tt = tt_b;
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      check("b_start_in_done", 32'({done_b, busy_b}), 32'b10);
      check("b_start_tt_hold", 32'(tt_b), 32'(hold_tt));
      @(negedge clk);
      ack_b = 1'b1;
      @(posedge clk);
      #1;
      ack_b = 1'b0;
      check("b_ack", 32'(done_b), 32'd0);
      @(negedge clk);
      start_b = 1'b1;
      abort_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      abort_b = 1'b0;
      check("b_start_abort", 32'(busy_b), 32'd0);
      @(posedge clk);
      #1;
      check("b_start_abort_2", 32'({busy_b, done_b}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
